// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command-queue driven APB3 requester with response hold and access timeout
//
// Purpose:
//   Commands {write, addr, wdata} are queued in an in-order FIFO. Each one is
//   issued as an APB3 transfer and produces exactly one response. A transfer
//   whose ACCESS phase sees no pready for TIMEOUT cycles is abandoned and
//   reported as an error with the timeout flag set.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err/rsp_timeout  response payload
//   m_apb_*                        APB3 requester interface

module apb_cmd_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] m_apb_paddr,
   output logic        m_apb_psel,
   output logic        m_apb_penable,
   output logic        m_apb_pwrite,
   output logic [31:0] m_apb_pwdata,
   input  logic        m_apb_pready,
   input  logic [31:0] m_apb_prdata,
   input  logic        m_apb_pslverr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]  FULL_COUNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0]  TO_LAST    = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t        state;
   logic [15:0]   wait_count;

   logic          fifo_write [FIFO_DEPTH];
   logic [31:0]   fifo_addr  [FIFO_DEPTH];
   logic [31:0]   fifo_wdata [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          push;
   logic          pop;

   // Ready depends only on the registered count, so a pop in the same
   // cycle never makes room for a push while the queue is full.
   assign cmd_ready = (count != FULL_COUNT);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == S_IDLE) && (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_write[wr_ptr] <= cmd_write;
         fifo_addr[wr_ptr]  <= cmd_addr;
         fifo_wdata[wr_ptr] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         wait_count    <= '0;
         m_apb_paddr   <= '0;
         m_apb_psel    <= 1'b0;
         m_apb_penable <= 1'b0;
         m_apb_pwrite  <= 1'b0;
         m_apb_pwdata  <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         rsp_timeout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  m_apb_paddr   <= fifo_addr[rd_ptr];
                  m_apb_pwrite  <= fifo_write[rd_ptr];
                  m_apb_pwdata  <= fifo_wdata[rd_ptr];
                  m_apb_psel    <= 1'b1;
                  m_apb_penable <= 1'b0;
                  wait_count    <= '0;
                  state         <= S_SETUP;
               end
            end
            S_SETUP: begin
               m_apb_penable <= 1'b1;
               state         <= S_ACCESS;
            end
            S_ACCESS: begin
               // pready wins over an expiring counter in the same cycle.
               if (m_apb_pready) begin
                  rsp_rdata     <= m_apb_pwrite ? 32'd0 : m_apb_prdata;
                  rsp_err       <= m_apb_pslverr;
                  rsp_timeout   <= 1'b0;
                  rsp_valid     <= 1'b1;
                  m_apb_psel    <= 1'b0;
                  m_apb_penable <= 1'b0;
                  state         <= S_RESP;
               end else begin
                  wait_count <= wait_count + 16'd1;
                  if (wait_count == TO_LAST) begin
                     rsp_rdata     <= '0;
                     rsp_err       <= 1'b1;
                     rsp_timeout   <= 1'b1;
                     rsp_valid     <= 1'b1;
                     m_apb_psel    <= 1'b0;
                     m_apb_penable <= 1'b0;
                     state         <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master

module tb_apb_cmd_master;

   logic        clk;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int checks;
   int failures;

   apb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .rsp_timeout   (rsp_timeout),
      .m_apb_paddr   (paddr),
      .m_apb_psel    (psel),
      .m_apb_penable (penable),
      .m_apb_pwrite  (pwrite),
      .m_apb_pwdata  (pwdata),
      .m_apb_pready  (pready),
      .m_apb_prdata  (prdata),
      .m_apb_pslverr (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   logic [31:0] addrs [6];
   logic [31:0] got [4];
   int          n;
   int          extra;
   logic        will;

   initial begin
      checks = 0; failures = 0;
      resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
      addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
      addrs[3] = 32'h10C; addrs[4] = 32'h110; addrs[5] = 32'h114;

      // reset state
      tick(); tick();
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      resetn = 1'b1;
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);

      // zero-wait write
      pready = 1'b1;
      push(1'b1, 32'h4, 32'h1F);
      chk("wr_idle_psel", psel, 0);
      tick();
      chk("wr_setup_psel", psel, 1);
      chk("wr_setup_penable", penable, 0);
      chk("wr_setup_paddr", paddr, 32'h4);
      chk("wr_setup_pwdata", pwdata, 32'h1F);
      chk("wr_setup_pwrite", pwrite, 1);
      tick();
      chk("wr_access_penable", penable, 1);
      chk("wr_access_paddr", paddr, 32'h4);
      chk("wr_access_pwdata", pwdata, 32'h1F);
      tick();
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_psel", psel, 0);
      chk("wr_rsp_err", rsp_err, 0);
      chk("wr_rsp_rdata", rsp_rdata, 0);
      chk("wr_rsp_timeout", rsp_timeout, 0);
      rsp_ready = 1'b1;
      tick();
      chk("wr_hs_rsp_valid", rsp_valid, 0);
      rsp_ready = 1'b0;
      pready = 1'b0;

      // read with 3 wait states and slave error; pslverr high while not ready
      push(1'b0, 32'h10, 32'h0);
      tick();
      chk("rd_setup_pwrite", pwrite, 0);
      chk("rd_setup_penable", penable, 0);
      prdata = 32'hDEADBEEF;
      pslverr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd_wait_psel", psel, 1);
         chk("rd_wait_penable", penable, 1);
         chk("rd_wait_paddr", paddr, 32'h10);
         chk("rd_wait_rsp_valid", rsp_valid, 0);
      end
      pready = 1'b1;
      tick();
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("rd_rsp_err", rsp_err, 1);
      chk("rd_rsp_timeout", rsp_timeout, 0);
      chk("rd_rsp_psel", psel, 0);
      pready = 1'b0; pslverr = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // timeout after 8 ACCESS cycles, then long-held response
      push(1'b1, 32'h20, 32'h55);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("to_wait_psel", psel, 1);
         chk("to_wait_penable", penable, 1);
         if (i == 2) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
         end
         if (i == 3) cmd_valid = 1'b0;
      end
      tick();
      chk("to_psel", psel, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_timeout", rsp_timeout, 1);
         chk("hold_rsp_err", rsp_err, 1);
         chk("hold_psel", psel, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("hold_hs_rsp_valid", rsp_valid, 0);
      chk("hold_hs_psel", psel, 0);
      rsp_ready = 1'b0;
      prdata = 32'h12345678;
      pready = 1'b1;
      tick();
      chk("q_setup_psel", psel, 1);
      chk("q_setup_paddr", paddr, 32'h30);
      tick();
      tick();
      chk("q_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("q_rsp_timeout", rsp_timeout, 0);
      chk("q_rsp_err", rsp_err, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // pready arrives in the cycle the counter would expire
      pready = 1'b0;
      push(1'b0, 32'h50, 32'h0);
      tick();
      for (int i = 0; i < 8; i++) tick();
      chk("edge_psel", psel, 1);
      pready = 1'b1;
      prdata = 32'hA5A5A5A5;
      tick();
      chk("edge_rsp_valid", rsp_valid, 1);
      chk("edge_rsp_timeout", rsp_timeout, 0);
      chk("edge_rsp_err", rsp_err, 0);
      chk("edge_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // fill the FIFO while the first response is stalled
      cmd_write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_addr  = addrs[i];
         cmd_wdata = 32'(i);
         chk("fill_ready", cmd_ready, 1);
         tick();
      end
      cmd_addr = addrs[5];
      chk("full_ready", cmd_ready, 0);
      chk("full_rsp_valid", rsp_valid, 1);
      chk("full_paddr0", paddr, addrs[0]);
      tick();
      chk("full_still_blocked", cmd_ready, 0);
      rsp_ready = 1'b1;
      tick();
      chk("full_idle_ready", cmd_ready, 0);
      chk("full_idle_rsp_valid", rsp_valid, 0);
      tick();
      chk("full_pop_refused", cmd_ready, 1);
      chk("full_pop_psel", psel, 1);
      chk("full_pop_paddr1", paddr, addrs[1]);
      n = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         will = cmd_valid && cmd_ready;
         tick();
         if (will) cmd_valid = 1'b0;
         if (psel && !penable) begin
            got[n] = paddr;
            n++;
         end
      end
      chk("order_count", 32'(n), 4);
      for (int k = 0; k < 4; k++) chk("order_addr", got[k], addrs[k+2]);
      extra = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (psel && !penable) extra++;
      end
      chk("order_no_dup", 32'(extra), 0);
      rsp_ready = 1'b0;

      // reset during ACCESS of a write with another command queued
      pready = 1'b0;
      push(1'b1, 32'h40, 32'h77);
      push(1'b1, 32'h44, 32'h88);
      tick();
      chk("mr_access_penable", penable, 1);
      chk("mr_access_paddr", paddr, 32'h40);
      resetn = 1'b0;
      tick();
      chk("mr_psel", psel, 0);
      chk("mr_penable", penable, 0);
      chk("mr_rsp_valid", rsp_valid, 0);
      chk("mr_paddr", paddr, 0);
      resetn = 1'b1;
      tick();
      chk("mr_cmd_ready", cmd_ready, 1);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (psel || rsp_valid) extra++;
      end
      chk("mr_fifo_empty", 32'(extra), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
